ffram_rmw_port: RTL and testbench
=================================

Name: ffram_rmw_port

Overview:
- Host-side write/read sequencer that sits directly upstream of the VDP's dual-port flip-flop RAM (palette, sprite attribute tables) and drives its port 0 (addr0/wdata0/we0, registered rdata0).
- Accepts a simple valid/ready command stream from the CPU register interface: set pointer, write with byte enables, read.
- Partial-byte writes use read-modify-write, because the RAM has only a full-word write enable.
- Maintains an auto-incrementing address pointer so the host can stream consecutive words.

Parameters:
- DATA_WIDTH, 16, RAM word width; must be a multiple of 8.
- ADDR_WIDTH, 8, RAM address width; pointer wraps modulo 2^ADDR_WIDTH.
- BE_WIDTH, DATA_WIDTH/8, number of byte-enable bits (derived).
- INC_STEP, 1, added to the pointer after every completed write or read.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_op  in  2  00 = set pointer, 01 = write, 10 = read, 11 = no-op (consumed, ignored).
- cmd_data  in  DATA_WIDTH  write data; low ADDR_WIDTH bits form the pointer for set-pointer.
- cmd_be  in  BE_WIDTH  byte enables for write; bit i covers data[8i+7:8i].
- rsp_valid  out  1  one-cycle pulse carrying read data; no backpressure.
- rsp_data  out  DATA_WIDTH  read result, valid only with rsp_valid.
- ram_addr0  out  ADDR_WIDTH  to RAM addr0; always equals the pointer register.
- ram_wdata0  out  DATA_WIDTH  to RAM wdata0.
- ram_we0  out  1  to RAM we0.
- ram_rdata0  in  DATA_WIDTH  from RAM rdata0; valid one cycle after the address is presented.
- pointer  out  ADDR_WIDTH  current pointer, for host status readback.

Behaviour:
- Reset (async assert, synchronous release in system): state=IDLE, pointer=0, rsp_valid=0, rsp_data=0, ram_we0=0, ram_wdata0=0, cmd_ready=1.
- States: IDLE, WRITE, FETCH, MERGE, RESP.
- cmd_ready = (state==IDLE), combinational.
- IDLE, on accept:
  - set-pointer: pointer <= cmd_data[ADDR_WIDTH-1:0]; stay in IDLE; no RAM access.
  - no-op: stay in IDLE.
  - write, cmd_be all ones: latch data -> WRITE.
  - write, partial cmd_be (nonzero, not all ones): latch data and be -> FETCH.
  - write, cmd_be==0: pointer += INC_STEP; stay in IDLE; no RAM access.
  - read: -> FETCH (read flag latched).
- WRITE (1 cycle): ram_we0=1, ram_wdata0=latched data; pointer += INC_STEP at end of cycle -> IDLE.
- FETCH (1 cycle): ram_we0=0; RAM samples ram_addr0.
  - write flag set: -> MERGE.
  - read flag set: -> RESP.
- MERGE (1 cycle): ram_wdata0 per byte = be[i] ? latched byte : ram_rdata0 byte; ram_we0=1; pointer += INC_STEP -> IDLE.
- RESP (1 cycle): rsp_valid=1, rsp_data=ram_rdata0; pointer += INC_STEP -> IDLE.
- Latencies from accept edge:
  - full write: RAM written 1 cycle later.
  - partial write: written 2 cycles later.
  - read: rsp_valid 2 cycles later.
- Throughput: next command accepted the cycle after the final state.
- ram_we0 is 0 in every state except WRITE and MERGE.
- ram_wdata0 is 0 when ram_we0=0.
- Pointer arithmetic is ADDR_WIDTH bits, so it wraps silently: 0xFF + 1 -> 0x00 for ADDR_WIDTH=8.
- The pointer is never modified while state!=IDLE except on the final-state increment. Commands cannot arrive mid-sequence because cmd_ready=0.
- Reset asserted mid-sequence: sequence abandoned, no RAM write occurs after reset asserts, rsp_valid stays 0, pointer returns to 0.
- Other RAM port (addr1/rdata1) belongs to the video read path and is untouched by this block. Port-0 write in MERGE is the same word fetched, so no hazard within the block.

Decomposition:
- Shared vdp package:
  - cmd_op encodings (OP_SET_PTR, OP_WRITE, OP_READ, OP_NOP).
  - state enum.
  - helper function byte_merge(old, new, be).
- No sub-module required. Byte-merge is a generate loop inside the block. The RAM is instantiated by the parent, not inside this block.

Test Plan (DATA_WIDTH=16, ADDR_WIDTH=8, INC_STEP=1, bench RAM model with 1-cycle read latency):
- Reset then set-pointer 0x10, write 0xABCD be=11 -> mem[0x10]=0xABCD one cycle after accept; pointer=0x11; cmd_ready low exactly 1 cycle.
- mem[0x20]=0x1234, set-pointer 0x20, write 0xFF00 be=10 -> ram_we0 in MERGE cycle with wdata 0xFF34; mem[0x20]=0xFF34; pointer=0x21.
- set-pointer 0x20, two back-to-back reads -> rsp_valid pulses 2 cycles after each accept with 0xFF34 then mem[0x21]; pointer=0x22.
- Pointer 0xFF, full write 0x5555 -> mem[0xFF]=0x5555, pointer wraps to 0x00; write be=00 -> no ram_we0, pointer=0x01.
- Partial write accepted, reset_n pulsed low during FETCH -> ram_we0 never asserts, target word unchanged, pointer=0, cmd_ready=1 after release.
- Randomised op stream with cmd_valid gaps, checked against a reference model of memory and pointer -> zero mismatches; ram_we0 never high in IDLE/FETCH/RESP.

Source files
------------

// File: rtl/ffram_rmw_port_pkg.sv
// Shared definitions for the host-side port-0 sequencer of the VDP flip-flop RAM.
package ffram_rmw_port_pkg;

  // Host command encodings carried on cmd_op.
  typedef enum logic [1:0] {
    OP_SET_PTR = 2'b00,
    OP_WRITE   = 2'b01,
    OP_READ    = 2'b10,
    OP_NOP     = 2'b11
  } cmd_op_e;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_FETCH,
    ST_MERGE,
    ST_RESP
  } state_e;

  // Select one byte lane: the new host byte when enabled, otherwise the stored byte.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       be);
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/ffram_rmw_port.sv
// Port-0 write/read sequencer for the VDP flip-flop RAM. Full-word writes go
// straight out; partial-byte writes fetch the word first and merge the enabled
// bytes, since the RAM only has a whole-word write enable. The address pointer
// auto-increments after every completed access.
module ffram_rmw_port
  import ffram_rmw_port_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int INC_STEP   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [BE_WIDTH-1:0]   cmd_be,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] ram_addr0,
  output logic [DATA_WIDTH-1:0] ram_wdata0,
  output logic                  ram_we0,
  input  logic [DATA_WIDTH-1:0] ram_rdata0,
  output logic [ADDR_WIDTH-1:0] pointer
);

  localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(INC_STEP);
  localparam logic [BE_WIDTH-1:0]   BE_FULL = {BE_WIDTH{1'b1}};

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic                    rd_q, rd_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [BE_WIDTH-1:0]     be_q, be_d;
  logic [DATA_WIDTH-1:0]   merged;

  // Per-byte merge of latched host data over the word fetched from the RAM.
  for (genvar i = 0; i < BE_WIDTH; i++) begin : g_merge
    assign merged[8*i +: 8] = byte_merge(ram_rdata0[8*i +: 8], data_q[8*i +: 8], be_q[i]);
  end

  assign ram_addr0 = ptr_q;
  assign pointer   = ptr_q;

  // Control state: sequencer state, pointer and read/write flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rd_q    <= rd_d;
    end
  end

  // Latched write payload; only meaningful once a write has been accepted.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    be_q   <= be_d;
  end

  // Next-state, pointer update and RAM/response outputs.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rd_d       = rd_q;
    data_d     = data_q;
    be_d       = be_q;
    cmd_ready  = 1'b0;
    ram_we0    = 1'b0;
    ram_wdata0 = '0;
    rsp_valid  = 1'b0;
    rsp_data   = '0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (cmd_op_e'(cmd_op))
            OP_SET_PTR: ptr_d = cmd_data[ADDR_WIDTH-1:0];
            OP_WRITE: begin
              if (cmd_be == BE_FULL) begin
                data_d  = cmd_data;
                state_d = ST_WRITE;
              end else if (cmd_be == '0) begin
                // Empty write still consumes a slot in the address stream.
                ptr_d = ptr_q + STEP;
              end else begin
                data_d  = cmd_data;
                be_d    = cmd_be;
                rd_d    = 1'b0;
                state_d = ST_FETCH;
              end
            end
            OP_READ: begin
              rd_d    = 1'b1;
              state_d = ST_FETCH;
            end
            default: ;
          endcase
        end
      end
      ST_WRITE: begin
        ram_we0    = 1'b1;
        ram_wdata0 = data_q;
        ptr_d      = ptr_q + STEP;
        state_d    = ST_IDLE;
      end
      ST_FETCH: begin
        // RAM samples ram_addr0 this cycle; data arrives in the next state.
        state_d = rd_q ? ST_RESP : ST_MERGE;
      end
      ST_MERGE: begin
        ram_we0    = 1'b1;
        ram_wdata0 = merged;
        ptr_d      = ptr_q + STEP;
        state_d    = ST_IDLE;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = ram_rdata0;
        ptr_d     = ptr_q + STEP;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ffram_rmw_port.sv
// Directed and randomised bench for ffram_rmw_port with a 1-cycle-latency RAM model.
module tb_ffram_rmw_port;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic [1:0]  cmd_be;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [7:0]  ram_addr0;
  logic [15:0] ram_wdata0;
  logic        ram_we0;
  logic [15:0] ram_rdata0;
  logic [7:0]  pointer;

  logic [15:0] mem [256] = '{default: 16'h0000};
  logic [15:0] exp_mem [256];
  int          n_checks = 0;
  int          n_errs   = 0;
  int          we_cnt   = 0;
  int          rsp_cnt  = 0;
  int          idle_we  = 0;
  logic [15:0] last_rsp = 16'h0;

  always #5 clk = ~clk;

  ffram_rmw_port #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(8),
    .INC_STEP  (1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_be    (cmd_be),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .ram_addr0 (ram_addr0),
    .ram_wdata0(ram_wdata0),
    .ram_we0   (ram_we0),
    .ram_rdata0(ram_rdata0),
    .pointer   (pointer)
  );

  // RAM model (registered read, read-before-write) plus activity monitors.
  always @(posedge clk) begin
    ram_rdata0 <= mem[ram_addr0];
    if (ram_we0) begin
      mem[ram_addr0] <= ram_wdata0;
      we_cnt <= we_cnt + 1;
      if (cmd_ready) idle_we <= idle_we + 1;
    end
    if (rsp_valid) begin
      rsp_cnt  <= rsp_cnt + 1;
      last_rsp <= rsp_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one command at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [1:0] op, input logic [15:0] d, input logic [1:0] be);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("send_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_be    = be;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'b11;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int          rc0, wc0, mism, exp_we;
    logic [7:0]  rptr;
    logic [1:0]  op, be;
    logic [15:0] d, expv;

    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b11;
    cmd_data  = 16'h0;
    cmd_be    = 2'b00;
    repeat (2) @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_ptr", pointer, 8'h00);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 16'h0);
    check("rst_we", ram_we0, 0);
    check("rst_wdata", ram_wdata0, 16'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Full write at 0x10.
    send(2'b00, 16'h0010, 2'b00);
    check("setptr", pointer, 8'h10);
    send(2'b01, 16'hABCD, 2'b11);
    check("fw_ready_low", cmd_ready, 0);
    check("fw_we", ram_we0, 1);
    check("fw_wdata", ram_wdata0, 16'hABCD);
    @(negedge clk);
    check("fw_ready_back", cmd_ready, 1);
    check("fw_mem", mem[8'h10], 16'hABCD);
    check("fw_ptr", pointer, 8'h11);

    // Preload 0x20=0x1234, 0x21=0xBEEF via full writes.
    send(2'b00, 16'h0020, 2'b00);
    send(2'b01, 16'h1234, 2'b11);
    send(2'b01, 16'hBEEF, 2'b11);
    wait_idle();
    check("preload", mem[8'h21], 16'hBEEF);

    // Partial write upper byte at 0x20.
    send(2'b00, 16'h0020, 2'b00);
    send(2'b01, 16'hFF00, 2'b10);
    check("pw_fetch_we", ram_we0, 0);
    check("pw_fetch_wdata", ram_wdata0, 16'h0);
    @(negedge clk);
    check("pw_merge_we", ram_we0, 1);
    check("pw_merge_wdata", ram_wdata0, 16'hFF34);
    @(negedge clk);
    check("pw_mem", mem[8'h20], 16'hFF34);
    check("pw_ptr", pointer, 8'h21);

    // Two back-to-back reads from 0x20.
    send(2'b00, 16'h0020, 2'b00);
    send(2'b10, 16'h0000, 2'b00);
    check("rd0_early", rsp_valid, 0);
    @(negedge clk);
    check("rd0_valid", rsp_valid, 1);
    check("rd0_data", rsp_data, 16'hFF34);
    send(2'b10, 16'h0000, 2'b00);
    check("rd1_early", rsp_valid, 0);
    @(negedge clk);
    check("rd1_valid", rsp_valid, 1);
    check("rd1_data", rsp_data, 16'hBEEF);
    @(negedge clk);
    check("rd1_pulse_end", rsp_valid, 0);
    check("rd_ptr", pointer, 8'h22);

    // Pointer wrap and empty write.
    send(2'b00, 16'h00FF, 2'b00);
    send(2'b01, 16'h5555, 2'b11);
    wait_idle();
    check("wrap_mem", mem[8'hFF], 16'h5555);
    check("wrap_ptr", pointer, 8'h00);
    wc0 = we_cnt;
    send(2'b01, 16'h9999, 2'b00);
    check("be0_ready", cmd_ready, 1);
    check("be0_we", ram_we0, 0);
    @(negedge clk);
    check("be0_nowrite", we_cnt, wc0);
    check("be0_ptr", pointer, 8'h01);

    // Reset during FETCH of a partial write.
    send(2'b00, 16'h0030, 2'b00);
    send(2'b01, 16'h0F0F, 2'b11);
    wait_idle();
    send(2'b00, 16'h0030, 2'b00);
    wc0 = we_cnt;
    send(2'b01, 16'hAAAA, 2'b01);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mid_nowrite", we_cnt, wc0);
    check("rst_mid_mem", mem[8'h30], 16'h0F0F);
    check("rst_mid_ptr", pointer, 8'h00);
    check("rst_mid_ready", cmd_ready, 1);
    check("rst_mid_rsp", rsp_cnt, 2);

    // Random op stream against a reference model.
    for (int i = 0; i < 256; i++) exp_mem[i] = mem[i];
    rptr   = pointer;
    exp_we = we_cnt;
    for (int k = 0; k < 80; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      op = 2'($urandom_range(0, 3));
      d  = 16'($urandom);
      be = 2'($urandom_range(0, 3));
      if (op == 2'b00) d[7:4] = 4'h4;
      rc0  = rsp_cnt;
      expv = exp_mem[rptr];
      case (op)
        2'b00: rptr = d[7:0];
        2'b01: begin
          if (be != 2'b00) begin
            if (be[0]) exp_mem[rptr][7:0]  = d[7:0];
            if (be[1]) exp_mem[rptr][15:8] = d[15:8];
            exp_we++;
          end
          rptr = rptr + 8'd1;
        end
        2'b10: rptr = rptr + 8'd1;
        default: ;
      endcase
      send(op, d, be);
      wait_idle();
      if (op == 2'b10) begin
        check("rnd_rsp_cnt", rsp_cnt, rc0 + 1);
        check("rnd_rsp_data", last_rsp, expv);
      end
      check("rnd_ptr", pointer, rptr);
    end
    @(negedge clk);
    mism = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) mism++;
    check("rnd_mem_all", mism, 0);
    check("rnd_we_cnt", we_cnt, exp_we);
    check("idle_we", idle_we, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
